// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch and load/store units.
// One transaction at a time; the LSU has priority, bounded by a starvation counter.
module mem_port_arbiter #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE     = 32'h8000_0000,
    parameter int                    STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      if_req_valid,
    output logic                      if_req_ready,
    input  logic [ADDR_WIDTH-1:0]     if_addr,
    output logic                      if_rsp_valid,
    output logic [DATA_WIDTH-1:0]     if_rsp_data,
    input  logic                      ls_req_valid,
    output logic                      ls_req_ready,
    input  logic                      ls_we,
    input  logic [DATA_WIDTH/8-1:0]   ls_mask,
    input  logic [ADDR_WIDTH-1:0]     ls_addr,
    input  logic [DATA_WIDTH-1:0]     ls_wdata,
    output logic                      ls_rsp_valid,
    output logic [DATA_WIDTH-1:0]     ls_rsp_data,
    output logic                      mem_req,
    input  logic                      mem_gnt,
    output logic                      mem_we,
    output logic [DATA_WIDTH/8-1:0]   mem_mask,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic                      mem_rvalid,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    localparam int            CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t                state_reg;
    state_t                state_next;
    logic [CNT_WIDTH-1:0]  starve_cnt_reg;
    logic                  owner_ls_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                  ls_win;
    logic                  capture;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        if_req_ready = 1'b0;
        ls_req_ready = 1'b0;
        mem_req      = 1'b0;
        if_rsp_valid = 1'b0;
        ls_rsp_valid = 1'b0;
        capture      = 1'b0;
        // LSU keeps priority until it has starved a waiting IFU STARVE_LIMIT times
        ls_win       = ls_req_valid && ((starve_cnt_reg < LIMIT) || !if_req_valid);
        case (state_reg)
            IDLE: begin
                ls_req_ready = ls_win;
                if_req_ready = if_req_valid && !ls_win;
                if (ls_win || if_req_valid) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    capture    = mem_rvalid;
                    state_next = mem_rvalid ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if_rsp_valid = !owner_ls_reg;
                ls_rsp_valid = owner_ls_reg;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            starve_cnt_reg <= '0;
            owner_ls_reg   <= 1'b0;
            mem_we         <= 1'b0;
            mem_mask       <= '0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            rdata_reg      <= '0;
        end else begin
            if (ls_req_ready) begin
                owner_ls_reg <= 1'b1;
                mem_we       <= ls_we;
                mem_mask     <= ls_mask;
                mem_addr     <= ls_addr - MEM_BASE;
                mem_wdata    <= ls_wdata;
                if (if_req_valid && (starve_cnt_reg < LIMIT)) begin
                    starve_cnt_reg <= starve_cnt_reg + CNT_WIDTH'(1);
                end
            end else if (if_req_ready) begin
                owner_ls_reg   <= 1'b0;
                mem_we         <= 1'b0;
                mem_mask       <= '1;
                mem_addr       <= if_addr - MEM_BASE;
                mem_wdata      <= '0;
                starve_cnt_reg <= '0;
            end
            // Stores return zero data to the LSU
            if (capture) begin
                rdata_reg <= mem_we ? '0 : mem_rdata;
            end
        end
    end

    assign if_rsp_data = rdata_reg;
    assign ls_rsp_data = rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts grants,
// memory-side fields and responses; a separate monitor checks response pulses.
module tb_mem_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MW = DW / 8;
    localparam int LIMIT = 2;
    localparam logic [AW-1:0] BASE = 32'h8000_0000;
    localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_RESP = 3;

    logic clk = 1'b0;
    logic arst_n;
    logic if_req_valid, if_req_ready, if_rsp_valid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rsp_data;
    logic ls_req_valid, ls_req_ready, ls_we, ls_rsp_valid;
    logic [MW-1:0] ls_mask;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata, ls_rsp_data;
    logic mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [MW-1:0] mem_mask;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_BASE(BASE), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_we(ls_we),
        .ls_mask(ls_mask), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_mask(mem_mask),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    typedef struct {
        bit            ls;
        logic          we;
        logic [MW-1:0] mask;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;
    typedef struct {
        bit            ls;
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    rsp_t rsp_q[$];
    bit dut_grants[$];
    req_t cur;
    int phase = P_IDLE;
    int starve = 0;
    int gnt_left, rv_left;
    int memreq_cnt = 0;

    int if_pct = 0, ls_pct = 0;
    bit noise = 0;
    bit fix_if = 0;
    logic [AW-1:0] fix_if_addr;
    bit fix_ls = 0;
    logic fix_we;
    logic [MW-1:0] fix_mask;
    logic [AW-1:0] fix_ls_addr;
    logic [DW-1:0] fix_wdata;
    bit fix_lat = 0;
    int fix_gnt, fix_rv;
    bit fix_rd = 0;
    logic [DW-1:0] fix_rdata;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic give_rsp();
        logic [DW-1:0] d;
        d = fix_rd ? fix_rdata : DW'($urandom);
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        rsp_q.push_back('{ls: cur.ls, data: (cur.we ? '0 : d), due: cyc + 1});
    endtask

    // One clock cycle: drive inputs mid-cycle, then check against the model.
    task automatic step();
        bit ifv, lsv, exp_if, exp_ls;
        int nxt;
        @(negedge clk);
        ifv = int'($urandom_range(99)) < if_pct;
        lsv = int'($urandom_range(99)) < ls_pct;
        if_req_valid = ifv;
        if_addr      = fix_if ? fix_if_addr : AW'($urandom);
        ls_req_valid = lsv;
        ls_we        = fix_ls ? fix_we : 1'($urandom_range(1));
        ls_mask      = fix_ls ? fix_mask : MW'($urandom);
        ls_addr      = fix_ls ? fix_ls_addr : AW'($urandom);
        ls_wdata     = fix_ls ? fix_wdata : DW'($urandom);
        mem_gnt      = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = DW'($urandom);
        nxt = phase;
        case (phase)
            P_REQ: begin
                if (gnt_left == 0) begin
                    mem_gnt = 1'b1;
                    if (rv_left == 0) begin
                        give_rsp();
                        nxt = P_RESP;
                    end else begin
                        nxt = P_WAIT;
                    end
                end else begin
                    gnt_left--;
                end
            end
            P_WAIT: begin
                rv_left--;
                if (rv_left == 0) begin
                    give_rsp();
                    nxt = P_RESP;
                end
            end
            default: mem_rvalid = noise && ($urandom_range(2) == 0);
        endcase
        #1;
        exp_if = 1'b0;
        exp_ls = 1'b0;
        if (phase == P_IDLE) begin
            exp_ls = lsv && ((starve < LIMIT) || !ifv);
            exp_if = ifv && !exp_ls;
        end
        chk("if_req_ready", if_req_ready, exp_if);
        chk("ls_req_ready", ls_req_ready, exp_ls);
        chk("mem_req", mem_req, phase == P_REQ);
        if (mem_req) memreq_cnt++;
        if (if_req_ready && ifv) dut_grants.push_back(1'b0);
        if (ls_req_ready && lsv) dut_grants.push_back(1'b1);
        if (phase == P_REQ) begin
            chk("mem_we", mem_we, cur.we);
            chk("mem_mask", mem_mask, cur.mask);
            chk("mem_addr", mem_addr, cur.addr);
            chk("mem_wdata", mem_wdata, cur.wdata);
        end
        if (exp_ls) begin
            cur = '{ls: 1'b1, we: ls_we, mask: ls_mask, addr: ls_addr - BASE, wdata: ls_wdata};
            if (ifv && starve < LIMIT) starve++;
        end else if (exp_if) begin
            cur = '{ls: 1'b0, we: 1'b0, mask: '1, addr: if_addr - BASE, wdata: '0};
            starve = 0;
        end
        if (exp_ls || exp_if) begin
            nxt = P_REQ;
            gnt_left = fix_lat ? fix_gnt : int'($urandom_range(3));
            rv_left  = fix_lat ? fix_rv : int'($urandom_range(2));
        end
        if (phase == P_RESP) nxt = P_IDLE;
        phase = nxt;
    endtask

    task automatic idle_inputs();
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        mem_gnt      = 1'b0;
        mem_rvalid   = 1'b0;
    endtask

    // Issue requests until one grant, then step until the transaction completes.
    task automatic run_one(input int ifp, input int lsp, input bit hold);
        int n;
        int g0;
        g0 = dut_grants.size();
        if_pct = ifp;
        ls_pct = lsp;
        n = 0;
        while (dut_grants.size() == g0 && n < 50) begin step(); n++; end
        if (!hold) begin if_pct = 0; ls_pct = 0; end
        n = 0;
        while (phase != P_IDLE && n < 50) begin step(); n++; end
        chk("transaction_done", (phase == P_IDLE) && (dut_grants.size() > g0), 1'b1);
        if_pct = 0;
        ls_pct = 0;
    endtask

    task automatic drain();
        int n;
        if_pct = 0;
        ls_pct = 0;
        n = 0;
        while (phase != P_IDLE && n < 50) begin step(); n++; end
        chk("drain_idle", phase == P_IDLE, 1'b1);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_if_req_ready"}, if_req_ready, 1'b0);
        chk({tag, "_ls_req_ready"}, ls_req_ready, 1'b0);
        chk({tag, "_rsp_valids"}, {if_rsp_valid, ls_rsp_valid}, 2'b00);
        chk({tag, "_rsp_data"}, {if_rsp_data, ls_rsp_data}, 64'h0);
        chk({tag, "_mem_req"}, mem_req, 1'b0);
        chk({tag, "_mem_fields"}, {mem_we, mem_mask, mem_addr[26:0]}, 64'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 64'h0);
    endtask

    // Response monitor: every cycle either the expected pulse or no pulse at all.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            #2;
            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                r = rsp_q.pop_front();
                chk("if_rsp_valid", if_rsp_valid, !r.ls);
                chk("ls_rsp_valid", ls_rsp_valid, r.ls);
                chk("rsp_data", r.ls ? ls_rsp_data : if_rsp_data, r.data);
                $display("rsp cycle=%0d owner=%s data=%h", cyc, r.ls ? "LSU" : "IFU", r.data);
            end else begin
                chk("no_rsp_pulse", if_rsp_valid || ls_rsp_valid, 1'b0);
            end
        end
    end

    initial begin
        int g0;
        int n;
        int pat[6] = '{1, 1, 0, 1, 1, 0};
        arst_n = 1'b0;
        idle_inputs();
        if_addr = '0; ls_we = 1'b0; ls_mask = '0; ls_addr = '0; ls_wdata = '0; mem_rdata = '0;
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        arst_n = 1'b1;

        // IFU-only fetch with same-cycle grant and response
        fix_if = 1; fix_if_addr = 32'h8000_0010;
        fix_lat = 1; fix_gnt = 0; fix_rv = 0;
        fix_rd = 1; fix_rdata = 32'hDEAD_BEEF;
        run_one(100, 0, 1'b0);
        fix_if = 0; fix_rd = 0;

        // Simultaneous requests: LSU first, IFU once the LSU lets go
        g0 = dut_grants.size();
        if_pct = 100; ls_pct = 100;
        n = 0;
        while (dut_grants.size() == g0 && n < 20) begin step(); n++; end
        ls_pct = 0;
        n = 0;
        while (dut_grants.size() < g0 + 2 && n < 20) begin step(); n++; end
        chk("both_grant_count", dut_grants.size(), g0 + 2);
        if (dut_grants.size() >= g0 + 2) begin
            chk("both_first_lsu", dut_grants[g0], 1'b1);
            chk("both_then_ifu", dut_grants[g0 + 1], 1'b0);
        end
        drain();

        // Both requesters continuously valid: starvation bound forces L,L,I
        g0 = dut_grants.size();
        if_pct = 100; ls_pct = 100;
        n = 0;
        while (dut_grants.size() < g0 + 6 && n < 60) begin step(); n++; end
        chk("starve_grant_count", dut_grants.size() >= g0 + 6, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (g0 + i < dut_grants.size()) chk("starve_grant_order", dut_grants[g0 + i], pat[i]);
        end
        drain();

        // Byte-masked store
        fix_ls = 1; fix_we = 1'b1; fix_mask = 4'b0011;
        fix_ls_addr = 32'h8000_0100; fix_wdata = 32'h1234_5678;
        run_one(0, 100, 1'b0);
        fix_ls = 0;

        // Slow memory: grant after 3 wait cycles, response 2 cycles later
        fix_gnt = 3; fix_rv = 2;
        memreq_cnt = 0;
        run_one(100, 0, 1'b1);
        chk("slow_mem_req_cycles", memreq_cnt, 4);

        // Reset while waiting on the memory response; the late response must vanish
        fix_gnt = 0; fix_rv = 6;
        g0 = dut_grants.size();
        ls_pct = 100;
        n = 0;
        while (dut_grants.size() == g0 && n < 20) begin step(); n++; end
        ls_pct = 0;
        n = 0;
        while (phase != P_WAIT && n < 20) begin step(); n++; end
        chk("reached_wait", phase == P_WAIT, 1'b1);
        idle_inputs();
        arst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        phase = P_IDLE;
        starve = 0;
        rsp_q.delete();
        @(negedge clk);
        arst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        fix_lat = 0;
        run_one(50, 50, 1'b0);

        // Randomised traffic with random memory latency and stray mem_rvalid
        noise = 1;
        for (int seg = 0; seg < 12; seg++) begin
            if_pct = int'($urandom_range(100));
            ls_pct = int'($urandom_range(100));
            repeat (50) step();
        end
        drain();
        idle_inputs();
        repeat (4) @(negedge clk);
        chk("rsp_queue_empty", rsp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
